// File: rtl/motion_arb_pkg.sv
// Shared constants for the motion arbiter: requester indices, command bit
// positions, FSM state encoding and active_mode codes.
package motion_arb_pkg;

  localparam int REQ_MANUAL = 0;
  localparam int REQ_SEMI   = 1;
  localparam int REQ_AUTO   = 2;

  localparam int CMD_FWD     = 5;
  localparam int CMD_BACK    = 4;
  localparam int CMD_LEFT    = 3;
  localparam int CMD_RIGHT   = 2;
  localparam int CMD_PLACE   = 1;
  localparam int CMD_DESTROY = 0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_GRANTED = 2'b01,
    ST_GAP     = 2'b10
  } arb_state_e;

  typedef enum logic [1:0] {
    MODE_NONE   = 2'd0,
    MODE_MANUAL = 2'd1,
    MODE_SEMI   = 2'd2,
    MODE_AUTO   = 2'd3
  } active_mode_e;

  // Maps a one-hot grant to the reported mode; anything else reads as none.
  function automatic logic [1:0] mode_of(input logic [2:0] g);
    logic [1:0] m;
    m = MODE_NONE;
    case (g)
      3'b001:  m = MODE_MANUAL;
      3'b010:  m = MODE_SEMI;
      3'b100:  m = MODE_AUTO;
      default: m = MODE_NONE;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/motion_arbiter_gap_timer.sv
// Handover gap timer: held at zero while i_load is high, counts while i_run
// is high, and flags o_done on the last cycle of a GAP_CYCLES-long gap.
module gap_timer
  import motion_arb_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int GAP_CYCLES = 250
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  input  logic i_run,
  output logic o_done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(GAP_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= '0;
    end else if (i_run) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_done = i_run && (r_cnt == LAST);

endmodule

// File: rtl/motion_arbiter.sv
// Fixed-priority owner arbiter for the car's motion path (manual > semi > auto)
// with a forced all-stop gap on every handover. Optional switch counter via
// `define MOTION_ARB_SWITCH_CNT_EN.
module motion_arbiter
  import motion_arb_pkg::*;
#(
  parameter int GAP_CYCLES = 250,
  parameter int CNT_W      = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] req,
  input  logic [5:0] cmd_manual,
  input  logic [5:0] cmd_semi,
  input  logic [5:0] cmd_auto,
  output logic [2:0] grant,
  output logic [2:0] owner_enable,
  output logic [5:0] motion_out,
  output logic       switching,
`ifdef MOTION_ARB_SWITCH_CNT_EN
  output logic [7:0] switch_cnt,
`endif
  output logic [1:0] active_mode
);

  arb_state_e r_state;
  arb_state_e w_state_nxt;
  logic [2:0] r_grant;
  logic [2:0] w_grant_nxt;
  logic [1:0] r_mode;
  logic [1:0] w_mode_nxt;
  logic [2:0] w_pick;
  logic [2:0] w_higher;
  logic [5:0] w_cmd_sel;
  logic       w_gap_done;
  logic       w_enter_gap;

  // Opposing command pairs cancel each other; independent bits pass through.
  function automatic logic [5:0] sanitize(input logic [5:0] c);
    logic [5:0] s;
    s = c;
    if (c[CMD_FWD] && c[CMD_BACK]) begin
      s[CMD_FWD]  = 1'b0;
      s[CMD_BACK] = 1'b0;
    end
    if (c[CMD_LEFT] && c[CMD_RIGHT]) begin
      s[CMD_LEFT]  = 1'b0;
      s[CMD_RIGHT] = 1'b0;
    end
    if (c[CMD_PLACE] && c[CMD_DESTROY]) begin
      s[CMD_PLACE]   = 1'b0;
      s[CMD_DESTROY] = 1'b0;
    end
    return s;
  endfunction

  always_comb begin
    w_pick = 3'b000;
    if (req[REQ_MANUAL])    w_pick = 3'b001;
    else if (req[REQ_SEMI]) w_pick = 3'b010;
    else if (req[REQ_AUTO]) w_pick = 3'b100;
  end

  // With a one-hot owner, owner-1 masks exactly the higher-priority requesters.
  assign w_higher = req & (r_grant - 3'd1);

  gap_timer #(
    .CNT_W      (CNT_W),
    .GAP_CYCLES (GAP_CYCLES)
  ) u_gap_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (r_state != ST_GAP),
    .i_run  (r_state == ST_GAP),
    .o_done (w_gap_done)
  );

  // State register together with the registered grant and mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_grant <= 3'b000;
      r_mode  <= MODE_NONE;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_mode  <= w_mode_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (|req) w_state_nxt = ST_GRANTED;
      end
      ST_GRANTED: begin
        if (((req & r_grant) == 3'b000) || (|w_higher)) w_state_nxt = ST_GAP;
      end
      ST_GAP: begin
        if (w_gap_done) w_state_nxt = (|req) ? ST_GRANTED : ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // A fresh owner is picked only when entering GRANTED; an owner keeps its grant.
  always_comb begin
    w_grant_nxt = 3'b000;
    if (w_state_nxt == ST_GRANTED) begin
      w_grant_nxt = (r_state == ST_GRANTED) ? r_grant : w_pick;
    end
    w_mode_nxt = mode_of(w_grant_nxt);
  end

  assign w_enter_gap = (r_state == ST_GRANTED) && (w_state_nxt == ST_GAP);

  always_comb begin
    w_cmd_sel = 6'b000000;
    case (r_grant)
      3'b001:  w_cmd_sel = cmd_manual;
      3'b010:  w_cmd_sel = cmd_semi;
      3'b100:  w_cmd_sel = cmd_auto;
      default: w_cmd_sel = 6'b000000;
    endcase
  end

  assign grant        = r_grant;
  assign owner_enable = r_grant;
  assign active_mode  = r_mode;
  assign switching    = (r_state == ST_GAP);
  assign motion_out   = sanitize(w_cmd_sel);

`ifdef MOTION_ARB_SWITCH_CNT_EN
  logic [7:0] r_switch_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_switch_cnt <= 8'd0;
    end else if (w_enter_gap && (r_switch_cnt != 8'hFF)) begin
      r_switch_cnt <= r_switch_cnt + 8'd1;
    end
  end

  assign switch_cnt = r_switch_cnt;
`else
  logic w_unused_enter_gap;
  assign w_unused_enter_gap = w_enter_gap;
`endif

endmodule

// File: tb/tb_motion_arbiter.sv
// Directed self-checking bench for motion_arbiter with a 4-cycle handover gap.
module tb_motion_arbiter;

  logic       clk;
  logic       rst_n;
  logic [2:0] req;
  logic [5:0] cmd_manual;
  logic [5:0] cmd_semi;
  logic [5:0] cmd_auto;
  logic [2:0] grant;
  logic [2:0] owner_enable;
  logic [5:0] motion_out;
  logic       switching;
  logic [1:0] active_mode;
`ifdef MOTION_ARB_SWITCH_CNT_EN
  logic [7:0] switch_cnt;
`endif

  int n_vec;
  int n_err;

  motion_arbiter #(
    .GAP_CYCLES (4),
    .CNT_W      (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .cmd_manual   (cmd_manual),
    .cmd_semi     (cmd_semi),
    .cmd_auto     (cmd_auto),
    .grant        (grant),
    .owner_enable (owner_enable),
    .motion_out   (motion_out),
    .switching    (switching),
`ifdef MOTION_ARB_SWITCH_CNT_EN
    .switch_cnt   (switch_cnt),
`endif
    .active_mode  (active_mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic [2:0] g, input logic [1:0] m,
                            input logic [5:0] mo, input logic sw);
    check_vec({tag, ".grant"}, 32'(grant), 32'(g));
    check_vec({tag, ".enable"}, 32'(owner_enable), 32'(g));
    check_vec({tag, ".mode"}, 32'(active_mode), 32'(m));
    check_vec({tag, ".motion"}, 32'(motion_out), 32'(mo));
    check_vec({tag, ".switching"}, 32'(switching), 32'(sw));
  endtask

  // Entry edge already taken: check the 4 gap cycles and the exit edge.
  task automatic run_gap(input string tag, input logic [2:0] g_exit, input logic [1:0] m_exit,
                         input logic [5:0] mo_exit);
    check_outs({tag, ".gap0"}, 3'b000, 2'd0, 6'b000000, 1'b1);
    for (int k = 1; k < 4; k++) begin
      step();
      check_outs({tag, ".gapN"}, 3'b000, 2'd0, 6'b000000, 1'b1);
    end
    step();
    check_outs({tag, ".exit"}, g_exit, m_exit, mo_exit, 1'b0);
  endtask

  task automatic wait_grant(input logic [2:0] g);
    int n;
    n = 0;
    while (grant !== g && n < 20) begin
      step();
      n++;
    end
    check_vec("wait_grant", 32'(grant), 32'(g));
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    req = 3'b000;
    cmd_manual = 6'b000000;
    cmd_semi = 6'b000000;
    cmd_auto = 6'b000000;
    #12;
    check_outs("reset", 3'b000, 2'd0, 6'b000000, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Auto from IDLE, no gap
    req = 3'b100;
    cmd_auto = 6'b100000;
    step();
    check_outs("auto_grant", 3'b100, 2'd3, 6'b100000, 1'b0);

    // Manual preempts auto
    req = 3'b101;
    cmd_manual = 6'b000001;
    step();
    run_gap("preempt", 3'b001, 2'd1, 6'b000001);

    // Semi request is ignored while manual owns; sanitiser cases
    req = 3'b011;
    cmd_manual = 6'b110000;
    #1;
    check_vec("san_fb", 32'(motion_out), 32'(6'b000000));
    cmd_manual = 6'b101100;
    #1;
    check_vec("san_lr", 32'(motion_out), 32'(6'b100000));
    cmd_manual = 6'b010011;
    #1;
    check_vec("san_pd", 32'(motion_out), 32'(6'b010000));
    cmd_manual = 6'b111111;
    #1;
    check_vec("san_all", 32'(motion_out), 32'(6'b000000));
    cmd_manual = 6'b011010;
    step();
    check_outs("low_ignored", 3'b001, 2'd1, 6'b011010, 1'b0);

    // Manual drops, semi gets it after the gap
    req = 3'b010;
    cmd_semi = 6'b001001;
    step();
    run_gap("to_semi", 3'b010, 2'd2, 6'b001001);

    // Semi drops; a one-cycle auto pulse inside the gap is forgotten
    req = 3'b000;
    step();
    check_outs("drop.gap0", 3'b000, 2'd0, 6'b000000, 1'b1);
    req = 3'b100;
    step();
    req = 3'b000;
    check_outs("drop.gap1", 3'b000, 2'd0, 6'b000000, 1'b1);
    step();
    step();
    check_outs("drop.gap3", 3'b000, 2'd0, 6'b000000, 1'b1);
    step();
    check_outs("drop.idle", 3'b000, 2'd0, 6'b000000, 1'b0);
    step();
    check_outs("drop.idle2", 3'b000, 2'd0, 6'b000000, 1'b0);

    // Asynchronous reset in the second gap cycle
    req = 3'b010;
    step();
    check_outs("semi_again", 3'b010, 2'd2, 6'b001001, 1'b0);
    req = 3'b000;
    step();
    step();
    check_vec("pre_rst.sw", 32'(switching), 32'd1);
    #2;
    rst_n = 1'b0;
    req = 3'b010;
    #1;
    check_outs("async_rst", 3'b000, 2'd0, 6'b000000, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_outs("post_rst", 3'b010, 2'd2, 6'b001001, 1'b0);

    // Owner drop and higher request on the same edge: one gap
    req = 3'b001;
    cmd_manual = 6'b000100;
    step();
    run_gap("drop_and_pre", 3'b001, 2'd1, 6'b000100);

`ifdef MOTION_ARB_SWITCH_CNT_EN
    check_vec("swcnt_one", 32'(switch_cnt), 32'd1);
    for (int i = 0; i < 300; i++) begin
      req = (i % 2 == 0) ? 3'b010 : 3'b001;
      step();
      wait_grant(req);
    end
    check_vec("swcnt_sat", 32'(switch_cnt), 32'd255);
    req = 3'b010;
    step();
    wait_grant(3'b010);
    check_vec("swcnt_hold", 32'(switch_cnt), 32'd255);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
